// File: rtl/random_range.sv
// random_range: turns raw LFSR output into an integer in [0, RANGE) over a req/valid handshake.
// Define RANDOM_RANGE_REJECT_EN for unbiased rejection sampling; otherwise a plain modulo is used.
module random_range #(
   parameter int NUM_BITS  = 8,
   parameter int RANGE     = 6,
   parameter int MAX_TRIES = 16,
   localparam int VAL_W    = ($clog2(RANGE) < 1) ? 1 : $clog2(RANGE)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                seed_req_i,
   input  logic [NUM_BITS-1:0] lfsr_data_i,
   output logic                lfsr_en_o,
   output logic                lfsr_seed_o,
   output logic [NUM_BITS-1:0] lfsr_seed_data_o,
   output logic                busy_o,
   output logic                valid_o,
   output logic [VAL_W-1:0]    value_o,
   output logic                fallback_o
);

   // IDLE wait | SEED load LFSR | STEP advance LFSR | CHECK accept or retry | OUT valid pulse
   typedef enum logic [2:0] {
      S_IDLE,
      S_SEED,
      S_STEP,
      S_CHECK,
      S_OUT
   } state_t;

   localparam logic [NUM_BITS-1:0] RANGE_N = RANGE[NUM_BITS-1:0];

   if (NUM_BITS < 3 || NUM_BITS > 32 || RANGE < 2 || MAX_TRIES < 1) begin : g_param_check
      $error("random_range: illegal parameter set");
   end

   state_t              state, state_nxt;
   logic [NUM_BITS-1:0] seed_cnt;
   logic [NUM_BITS-1:0] residue;
   logic                accept;

   assign residue = lfsr_data_i % RANGE_N;

`ifdef RANDOM_RANGE_REJECT_EN
   localparam longint unsigned SPAN    = 64'd1 << NUM_BITS;
   localparam longint unsigned LIMIT_L = (SPAN / 64'(RANGE)) * 64'(RANGE);
   localparam logic [NUM_BITS:0] LIMIT = LIMIT_L[NUM_BITS:0];
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   logic [TRY_W-1:0] try_cnt;
   logic             in_limit;
   logic             last_try;

   assign in_limit = {1'b0, lfsr_data_i} < LIMIT;
   assign last_try = try_cnt == TRY_W'(MAX_TRIES);
   assign accept   = in_limit | last_try;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         try_cnt    <= '0;
         fallback_o <= 1'b0;
      end else begin
         if (state == S_IDLE && !seed_req_i && req_i)
            try_cnt <= TRY_W'(1);
         else if (state == S_CHECK && !accept)
            try_cnt <= try_cnt + 1'b1;
         if (state == S_CHECK && accept)
            fallback_o <= !in_limit;
      end
   end
`else
   assign accept     = 1'b1;
   assign fallback_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (seed_req_i)
               state_nxt = S_SEED;
            else if (req_i)
               state_nxt = S_STEP;
         end
         S_SEED:  state_nxt = S_IDLE;
         S_STEP:  state_nxt = S_CHECK;
         S_CHECK: state_nxt = accept ? S_OUT : S_STEP;
         S_OUT:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // All-ones is the XNOR LFSR lock-up state, so it is never used as a seed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         seed_cnt         <= '0;
         lfsr_seed_data_o <= '0;
         value_o          <= '0;
      end else begin
         seed_cnt <= seed_cnt + 1'b1;
         if (state == S_IDLE && seed_req_i)
            lfsr_seed_data_o <= (&seed_cnt) ? '0 : seed_cnt;
         if (state == S_CHECK && accept)
            value_o <= residue[VAL_W-1:0];
      end
   end

   assign busy_o      = state != S_IDLE;
   assign valid_o     = state == S_OUT;
   assign lfsr_en_o   = (state == S_SEED) || (state == S_STEP);
   assign lfsr_seed_o = state == S_SEED;

endmodule
